// File: rtl/seq_logic_alu.sv
// -----------------------------------------------------------------------------
// seq_logic_alu
//
// Sequential logic/shift unit with a start/busy/done handshake. Logic and
// unary ops complete one cycle after acceptance. Shifts step one bit per
// cycle, with the distance clamped to N. result and the flags are registered
// and change only on the cycle done is high.
//
// Ports
//   clk     in   rising-edge clock
//   rst     in   asynchronous, active-high reset
//   start   in   operation request, accepted only while busy = 0
//   op      in   3-bit opcode:
//                  000 AND, 001 OR, 010 XOR, 011 SHR, 100 SHL,
//                  101 ASR, 110 NOT a, 111 MOV a
//   a       in   N-bit operand A (also the shift source)
//   b       in   N-bit operand B (also the unsigned shift distance)
//   busy    out  high while a shift is iterating
//   done    out  high on the cycle result/flags were updated
//   result  out  N-bit registered result
//   flag_z  out  result == 0
//   flag_n  out  result MSB
//   flag_c  out  last bit shifted out (0 for non-shift ops)
// -----------------------------------------------------------------------------
module seq_logic_alu #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [2:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         flag_z,
    output logic         flag_n,
    output logic         flag_c
);

    // The counter must hold values 0..N.
    localparam int CW = $clog2(N + 1);
    localparam logic [N-1:0]  N_B   = N'(N);
    localparam logic [CW-1:0] N_CNT = CW'(N);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_SHR = 3'b011;
    localparam logic [2:0] OP_SHL = 3'b100;
    localparam logic [2:0] OP_ASR = 3'b101;
    localparam logic [2:0] OP_NOT = 3'b110;
    localparam logic [2:0] OP_MOV = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [2:0]     r_op;
    logic [N-1:0]   r_sh;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_result;
    logic           r_flag_z;
    logic           r_flag_n;
    logic           r_flag_c;

    logic           w_accept;
    logic           w_is_shift;
    logic [CW-1:0]  w_cnt_init;
    logic [N-1:0]   w_logic;
    logic [N-1:0]   w_sh_next;
    logic           w_sh_out;

    // Non-shift opcodes. Shift opcodes never reach the result through this
    // function, so they fall through to a pass-through.
    function automatic logic [N-1:0] f_logic(input logic [2:0] f_op,
                                             input logic [N-1:0] f_a,
                                             input logic [N-1:0] f_b);
        logic [N-1:0] v;
        case (f_op)
            OP_AND:  v = f_a & f_b;
            OP_OR:   v = f_a | f_b;
            OP_XOR:  v = f_a ^ f_b;
            OP_NOT:  v = ~f_a;
            OP_MOV:  v = f_a;
            default: v = f_a;
        endcase
        return v;
    endfunction

    // A start arriving during SHIFT is dropped without latching anything.
    assign w_accept   = start && (r_state != S_SHIFT);
    assign w_is_shift = (op == OP_SHR) || (op == OP_SHL) || (op == OP_ASR);
    // Distances of N or more collapse to N steps. When b < N, b also fits in CW bits.
    assign w_cnt_init = (b >= N_B) ? N_CNT : b[CW-1:0];
    assign w_logic    = f_logic(op, a, b);

    // One-bit step of the shift register, using the latched opcode.
    always_comb begin
        w_sh_next = r_sh;
        w_sh_out  = 1'b0;
        case (r_op)
            OP_SHL: begin
                w_sh_next = {r_sh[N-2:0], 1'b0};
                w_sh_out  = r_sh[N-1];
            end
            OP_ASR: begin
                w_sh_next = {r_sh[N-1], r_sh[N-1:1]};
                w_sh_out  = r_sh[0];
            end
            default: begin
                w_sh_next = {1'b0, r_sh[N-1:1]};
                w_sh_out  = r_sh[0];
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    if (w_is_shift && (w_cnt_init != '0)) begin
                        w_next = S_SHIFT;
                    end else begin
                        w_next = S_DONE;
                    end
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_SHIFT: begin
                // r_cnt is never 0 in SHIFT. The step with r_cnt == 1 is the last one.
                if (r_cnt == CW'(1)) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_SHIFT;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (r_state)
            S_SHIFT: busy = 1'b1;
            S_DONE:  done = 1'b1;
            default: begin
                busy = 1'b0;
                done = 1'b0;
            end
        endcase
    end

    // Datapath: operand latches, shift register, counter, result and flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op     <= '0;
            r_sh     <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_flag_z <= 1'b1;
            r_flag_n <= 1'b0;
            r_flag_c <= 1'b0;
        end else if (w_accept) begin
            r_op  <= op;
            r_sh  <= a;
            r_cnt <= w_is_shift ? w_cnt_init : '0;
            if (!w_is_shift) begin
                r_result <= w_logic;
                r_flag_z <= (w_logic == '0);
                r_flag_n <= w_logic[N-1];
                r_flag_c <= 1'b0;
            end else if (w_cnt_init == '0) begin
                // Zero-distance shift completes at once with the source unchanged.
                r_result <= a;
                r_flag_z <= (a == '0);
                r_flag_n <= a[N-1];
                r_flag_c <= 1'b0;
            end
        end else if (r_state == S_SHIFT) begin
            r_sh  <= w_sh_next;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) begin
                r_result <= w_sh_next;
                r_flag_z <= (w_sh_next == '0);
                r_flag_n <= w_sh_next[N-1];
                r_flag_c <= w_sh_out;
            end
        end
    end

    assign result = r_result;
    assign flag_z = r_flag_z;
    assign flag_n = r_flag_n;
    assign flag_c = r_flag_c;

endmodule

// File: tb/tb_seq_logic_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_logic_alu
//
// Directed bench for seq_logic_alu with N = 4. Inputs change on the falling
// edge. Outputs are sampled on the falling edge, after each rising edge.
// -----------------------------------------------------------------------------
module tb_seq_logic_alu;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic       flag_z;
    logic       flag_n;
    logic       flag_c;

    int n_cmp;
    int n_err;

    seq_logic_alu #(.N(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .flag_z (flag_z),
        .flag_n (flag_n),
        .flag_c (flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then return on the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_out(input string tag, input logic e_busy, input logic e_done,
                           input logic [3:0] e_res, input logic e_z, input logic e_n,
                           input logic e_c);
        chk({tag, ".busy"},   busy,   e_busy);
        chk({tag, ".done"},   done,   e_done);
        chk({tag, ".result"}, result, e_res);
        chk({tag, ".z"},      flag_z, e_z);
        chk({tag, ".n"},      flag_n, e_n);
        chk({tag, ".c"},      flag_c, e_c);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        a     = 4'b0000;
        b     = 4'b0000;
        tick();
        tick();
        chk_out("reset", 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk_out("idle", 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);

        // AND 1100 & 1010 = 1000
        start = 1'b1; op = 3'b000; a = 4'b1100; b = 4'b1010;
        tick();
        start = 1'b0;
        chk_out("and", 1'b0, 1'b1, 4'b1000, 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("and_hold", 1'b0, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0);

        // SHL 0011 by 2 = 1100, c = 0. Operand change after acceptance must not matter.
        start = 1'b1; op = 3'b100; a = 4'b0011; b = 4'd2;
        tick();
        start = 1'b0; a = 4'b1111; b = 4'd0;
        chk("shl.busy0", busy, 1'b1);
        chk("shl.done0", done, 1'b0);
        chk("shl.res_held", result, 4'b1000);
        tick();
        chk("shl.busy1", busy, 1'b1);
        chk("shl.done1", done, 1'b0);
        tick();
        chk_out("shl", 1'b0, 1'b1, 4'b1100, 1'b0, 1'b1, 1'b0);
        tick();
        chk("shl.done_pulse", done, 1'b0);

        // ASR 1000 by 7 (clamped to 4) = 1111, c = 1
        start = 1'b1; op = 3'b101; a = 4'b1000; b = 4'd7;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("asr.busy", busy, 1'b1);
            chk("asr.done_early", done, 1'b0);
            tick();
        end
        chk_out("asr", 1'b0, 1'b1, 4'b1111, 1'b0, 1'b1, 1'b1);
        tick();

        // SHR 0001 by 1 = 0000, c = 1. An XOR request during busy is ignored.
        start = 1'b1; op = 3'b011; a = 4'b0001; b = 4'd1;
        tick();
        chk("shr.busy", busy, 1'b1);
        op = 3'b010; a = 4'b0110; b = 4'b0101;
        tick();
        chk_out("shr", 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
        tick();
        start = 1'b0;
        chk_out("xor_after_busy", 1'b0, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);
        tick();
        chk("xor.done_pulse", done, 1'b0);

        // MOV 0000 so the next XOR result is distinguishable
        start = 1'b1; op = 3'b111; a = 4'b0000; b = 4'b0000;
        tick();
        chk_out("mov0", 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b0);

        // Back-to-back XOR then NOT with start held high
        op = 3'b010; a = 4'b0110; b = 4'b0101;
        tick();
        chk_out("b2b_xor", 1'b0, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0);
        op = 3'b110; a = 4'b0110;
        tick();
        start = 1'b0;
        chk_out("b2b_not", 1'b0, 1'b1, 4'b1001, 1'b0, 1'b1, 1'b0);
        tick();
        chk("b2b.done_end", done, 1'b0);

        // SHR by 0: completes after one cycle, result = a, c = 0
        start = 1'b1; op = 3'b011; a = 4'b1011; b = 4'd0;
        tick();
        start = 1'b0;
        chk_out("shr0", 1'b0, 1'b1, 4'b1011, 1'b0, 1'b1, 1'b0);
        tick();

        // SHL 1001 by 15 (clamped to 4) = 0000, c = last bit out = 1
        start = 1'b1; op = 3'b100; a = 4'b1001; b = 4'd15;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("shlc.busy_last", busy, 1'b1);
        tick();
        chk_out("shl_clamp", 1'b0, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
        tick();

        // Reset during the second SHIFT cycle of SHL 0001 by 3
        start = 1'b1; op = 3'b100; a = 4'b0001; b = 4'd3;
        tick();
        start = 1'b0;
        chk("rstmid.busy1", busy, 1'b1);
        tick();
        chk("rstmid.busy2", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk_out("rstmid.async", 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        chk_out("rstmid.nodone1", 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);
        tick();
        chk_out("rstmid.nodone2", 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b0);

        // MOV 1010 after the aborted shift
        start = 1'b1; op = 3'b111; a = 4'b1010; b = 4'b0000;
        tick();
        start = 1'b0;
        chk_out("mov", 1'b0, 1'b1, 4'b1010, 1'b0, 1'b1, 1'b0);

        // OR 0101 | 0010 = 0111
        start = 1'b1; op = 3'b001; a = 4'b0101; b = 4'b0010;
        tick();
        start = 1'b0;
        chk_out("or", 1'b0, 1'b1, 4'b0111, 1'b0, 1'b0, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
